adder_accumulator: RTL
======================

# adder_accumulator

Sequential accumulate stage wrapped around the combinational multi-bit `adder` (ports `A`, `B`, `Cin`, `Sum`, `Cout`). It accepts a frame of operands over a valid/ready handshake and drives the running accumulator and each new operand into the adder. It registers the adder's `Sum` back into the accumulator and counts carry-outs. At the end of the frame it presents the total, the carry count and the beat count on an output valid/ready handshake. The adder is instantiated beside this block, not inside it: this block feeds `A`/`B`/`Cin` and consumes `Sum`/`Cout` in the same cycle.

## Interface
- `WIDTH`, 8, operand, accumulator and adder width; must equal the adder's `WIDTH`.
- `CNT_WIDTH`, 4, carry-count width.
- `BEAT_WIDTH`, 8, beat-count width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  operand.
- `in_cin`  in  1  carry-in for this beat.
- `in_last`  in  1  final beat of the frame.
- `add_a`  out  WIDTH  to adder `A`.
- `add_b`  out  WIDTH  to adder `B`.
- `add_cin`  out  1  to adder `Cin`.
- `add_sum`  in  WIDTH  from adder `Sum`.
- `add_cout`  in  1  from adder `Cout`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  WIDTH  frame total modulo 2^WIDTH.
- `out_carries`  out  CNT_WIDTH  number of beats whose `add_cout` was 1, saturating.
- `out_carry_sat`  out  1  carry count saturated.
- `out_beats`  out  BEAT_WIDTH  beats accepted in the frame, saturating at all-ones.

## Operation
- States: ACCUM (`in_ready`=1, `out_valid`=0) and RESULT (`in_ready`=0, `out_valid`=1).
- Adder drive, combinational and in every state:
  - `add_a` = acc
  - `add_b` = `in_data`
  - `add_cin` = `in_cin`
- Beat accepted when `in_valid && in_ready`. On acceptance:
  - acc <= `add_sum`.
  - If `add_cout`, carries <= carries+1. At all-ones, carries holds and `carry_sat` <= 1 (sticky).
  - beats <= beats+1, saturating.
  - If `in_last`, go to RESULT.
- In ACCUM with `in_valid`=0, no state changes.
- RESULT:
  - `out_sum`, `out_carries`, `out_carry_sat` and `out_beats` are the registered acc, carries, `carry_sat` and beats.
  - These outputs hold stable while `out_valid && !out_ready`.
  - `in_valid` is ignored.
- Result handshake (`out_valid && out_ready`): acc, carries, `carry_sat` and beats clear to 0, and the state returns to ACCUM.
- First beat of every frame therefore computes 0 + `in_data` + `in_cin`.
- Arithmetic is modulo 2^WIDTH; overflow is reported only through `out_carries`.
- Reset: state ACCUM, and acc, carries, `carry_sat`, beats all 0.
  - `out_valid`=0 and `out_sum`=0 after reset.
  - `in_ready`=1 from the first cycle after `rst` deasserts.
- Reset mid-frame or in RESULT discards all partial state; no result is emitted.

## Timing
- Adder path is combinational within one cycle: acc → `add_a` → adder → `add_sum` → acc register.
- Result latency: `out_valid` asserts the cycle after the `in_last` beat is accepted.
- After the result handshake, `in_ready` reasserts the next cycle. This one-cycle bubble per frame is required.
- Throughput within a frame: one beat per cycle.
- `in_ready` depends only on state, never combinationally on `in_valid`.
- `out_valid` never drops without a handshake, except on `rst`.

## Test plan
- WIDTH=8. Beats 10, 20, 30 (last on 30), `cin`=0 → `out_sum`=60, `out_carries`=0, `out_beats`=3, `out_valid` on the cycle after beat 3.
- Beats 200, 100 (last) → `out_sum`=44, `out_carries`=1, `out_beats`=2. Single beat 255 with `cin`=1, last → `out_sum`=0, `out_carries`=1, `out_beats`=1.
- 20 back-to-back beats of 255, `CNT_WIDTH`=4 → `out_sum`=236, `out_carries`=15, `out_carry_sat`=1, `out_beats`=20, with `in_ready` high throughout.
- Backpressure: `out_ready`=0 for 5 cycles after the result with `in_valid`=1 held → outputs stable, `in_ready`=0, no beat absorbed. Then `out_ready`=1 → next frame 7 (last) gives `out_sum`=7.
- Reset mid-frame: accept 10 and 20, pulse `rst` for 1 cycle, then send 5 (last) → `out_sum`=5, `out_beats`=1, `out_carries`=0. During the reset cycle `out_valid`=0.
- Adder hookup: on every accepted beat, `add_a` equals the previous acc and `add_b` equals `in_data`. Check with random `$random(seed)` operands against a reference sum over 15 frames.

Source files
------------

// File: rtl/adder_accumulator.sv
// Frame accumulator that drives an external combinational adder and registers
// its sum, counting carry-outs and beats until the last beat of each frame.
module adder_accumulator #(
  parameter int WIDTH      = 8,
  parameter int CNT_WIDTH  = 4,
  parameter int BEAT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_cin,
  input  logic                  in_last,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic [CNT_WIDTH-1:0]  out_carries,
  output logic                  out_carry_sat,
  output logic [BEAT_WIDTH-1:0] out_beats
);

  typedef enum logic {ACCUM, RESULT} state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  carries_q, carries_d;
  logic                  carry_sat_q, carry_sat_d;
  logic [BEAT_WIDTH-1:0] beats_q, beats_d;
  logic                  accept;

  assign add_a   = acc_q;
  assign add_b   = in_data;
  assign add_cin = in_cin;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == RESULT);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    carry_sat_d = carry_sat_q;
    beats_d     = beats_q;
    if (accept) begin
      acc_d = add_sum;
      if (add_cout) begin
        if (carries_q == '1) carry_sat_d = 1'b1;
        else                 carries_d   = carries_q + CNT_WIDTH'(1);
      end
      if (beats_q != '1) beats_d = beats_q + BEAT_WIDTH'(1);
      if (in_last) state_d = RESULT;
    end
    if (out_valid && out_ready) begin
      state_d     = ACCUM;
      acc_d       = '0;
      carries_d   = '0;
      carry_sat_d = 1'b0;
      beats_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      carries_q   <= '0;
      carry_sat_q <= 1'b0;
      beats_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      carry_sat_q <= carry_sat_d;
      beats_q     <= beats_d;
    end
  end

  assign out_sum       = acc_q;
  assign out_carries   = carries_q;
  assign out_carry_sat = carry_sat_q;
  assign out_beats     = beats_q;

endmodule
